// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state codes,
// the received-frame record and small parity/voting helpers.
package uart_rx_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE       = 3'd0;
    localparam rx_state_t ST_START      = 3'd1;
    localparam rx_state_t ST_DATA       = 3'd2;
    localparam rx_state_t ST_PARITY     = 3'd3;
    localparam rx_state_t ST_STOP       = 3'd4;
    localparam rx_state_t ST_BREAK_WAIT = 3'd5;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     ferr;
        logic                     perr;
    } rx_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic xor_reduce(input logic [MAX_DATA_BITS-1:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through frame buffer; a push into a full buffer is
// accepted when a pop happens on the same edge.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

    // Head entry, forced to zero while empty
    always_comb begin
        if (empty) rdata = '0;
        else       rdata = mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with runtime parity and a FWFT frame FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting over the samples ending at each decision tick.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_sample,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    input  logic                 Rx_PARITY_EN,
    input  logic                 Rx_PARITY_ODD,
    input  logic                 Rx_READY,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR,
    output logic                 Rx_VALID,
    output logic                 Rx_OVERRUN
);

    localparam int               CNT_W     = $clog2(OVERSAMPLE);
    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam int               ENTRY_W   = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] START_MID = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] BIT_MID   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    logic                 sync1_r, sync2_r;
    rx_state_t            state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 ferr_r, perr_r;
    logic                 par_en_r, par_odd_r;
    logic                 overrun_r;

    logic                 line_s, bit_s, at_mid_s, last_stop_s, par_exp_s;
    logic                 push_s, pop_s, full_s, empty_s;
    rx_entry_t            entry_s;
    logic [ENTRY_W-1:0]   head_s;

    assign line_s = sync2_r;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= RxD;
            sync2_r <= sync1_r;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_r;

    // Last two tick samples; with the current one they form the vote window
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          hist_r <= 2'b11;
        else if (!Rx_EN)    hist_r <= 2'b11;
        else if (Rx_sample) hist_r <= {hist_r[0], line_s};
        else                hist_r <= hist_r;
    end

    assign bit_s = maj3(hist_r[1], hist_r[0], line_s);
`else
    assign bit_s = line_s;
`endif

    // Decision point, frame record and push strobe for the current tick
    always_comb begin
        at_mid_s    = (state_r == ST_START) ? (cnt_r == START_MID) : (cnt_r == BIT_MID);
        last_stop_s = (stop_idx_r == LAST_STOP);
        entry_s                      = '0;
        entry_s.data[DATA_BITS-1:0]  = data_r;
        entry_s.ferr                 = ferr_r | ~bit_s;
        entry_s.perr                 = perr_r;
        par_exp_s   = xor_reduce(entry_s.data) ^ par_odd_r;
        if (Rx_EN && Rx_sample && (state_r == ST_STOP) && at_mid_s && last_stop_s) push_s = 1'b1;
        else                                                                        push_s = 1'b0;
    end

    // Frame reception state machine, advanced only on oversample ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            data_r     <= '0;
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
        end else if (!Rx_EN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_idx_r  <= '0;
            stop_idx_r <= 1'b0;
            data_r     <= '0;
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
        end else if (Rx_sample) begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (!line_s) state_r <= ST_START;
                end
                ST_START: begin
                    if (at_mid_s) begin
                        cnt_r <= '0;
                        if (!bit_s) begin
                            state_r    <= ST_DATA;
                            par_en_r   <= Rx_PARITY_EN;
                            par_odd_r  <= Rx_PARITY_ODD;
                            bit_idx_r  <= '0;
                            stop_idx_r <= 1'b0;
                            ferr_r     <= 1'b0;
                            perr_r     <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (at_mid_s) begin
                        cnt_r  <= '0;
                        data_r <= {bit_s, data_r[DATA_BITS-1:1]};
                        if (bit_idx_r == LAST_BIT) begin
                            bit_idx_r <= '0;
                            state_r   <= par_en_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (at_mid_s) begin
                        cnt_r   <= '0;
                        perr_r  <= (bit_s != par_exp_s);
                        state_r <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (at_mid_s) begin
                        cnt_r  <= '0;
                        ferr_r <= ferr_r | ~bit_s;
                        if (last_stop_s) begin
                            stop_idx_r <= 1'b0;
                            state_r    <= bit_s ? ST_IDLE : ST_BREAK_WAIT;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_BREAK_WAIT: begin
                    cnt_r <= '0;
                    if (line_s) state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign pop_s = Rx_VALID & Rx_READY;

    // Sticky record of frames dropped against a full buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             overrun_r <= 1'b0;
        else if (!Rx_EN)                       overrun_r <= 1'b0;
        else if (push_s && full_s && !pop_s)   overrun_r <= 1'b1;
        else                                   overrun_r <= overrun_r;
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (~Rx_EN),
        .push  (push_s),
        .wdata ({entry_s.data[DATA_BITS-1:0], entry_s.ferr, entry_s.perr}),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign Rx_VALID   = ~empty_s;
    assign Rx_DATA    = head_s[ENTRY_W-1:2];
    assign Rx_FERROR  = head_s[1];
    assign Rx_PERROR  = head_s[0];
    assign Rx_OVERRUN = overrun_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param: an 8-bit/1-stop instance and
// a 7-bit/2-stop instance share clock, tick and control inputs.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic clk = 1'b0, reset = 1'b1, tick = 1'b0, en = 1'b1;
    logic rxd8 = 1'b1, rxd7 = 1'b1, pen = 1'b0, podd = 1'b0, ready = 1'b1;
    logic [7:0] data8;
    logic [6:0] data7;
    logic fe8, pe8, v8, ov8, fe7, pe7, v7, ov7;
    int checks = 0, failures = 0;
    logic [10:0] q8[$];
    logic [10:0] q7[$];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .Rx_sample(tick), .Rx_EN(en), .RxD(rxd8),
        .Rx_PARITY_EN(pen), .Rx_PARITY_ODD(podd), .Rx_READY(ready),
        .Rx_DATA(data8), .Rx_FERROR(fe8), .Rx_PERROR(pe8), .Rx_VALID(v8), .Rx_OVERRUN(ov8));

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut7 (
        .clk(clk), .reset(reset), .Rx_sample(tick), .Rx_EN(en), .RxD(rxd7),
        .Rx_PARITY_EN(pen), .Rx_PARITY_ODD(podd), .Rx_READY(1'b1),
        .Rx_DATA(data7), .Rx_FERROR(fe7), .Rx_PERROR(pe7), .Rx_VALID(v7), .Rx_OVERRUN(ov7));

    always #5 clk = ~clk;

    // Oversample tick on every other clock
    initial forever begin
        @(posedge clk);
        #1 tick = ~tick;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #2;
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 7) rxd7 = b;
        else            rxd8 = b;
    endtask

    task automatic idle(input int n);
        rxd8 = 1'b1;
        rxd7 = 1'b1;
        wait_ticks(n);
    endtask

    // Serialise one frame; the expected record is queued before the stop bits
    task automatic send_frame(input int which, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input bit expect_push, input bit pop_at_push);
        int   nbits = (which == 7) ? 7 : 8;
        int   nstop = (which == 7) ? 2 : 1;
        logic fe, pe;
        drive(which, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            wait_ticks(OS);
        end
        if (pen) begin
            drive(which, pbit);
            wait_ticks(OS);
        end
        fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        pe = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
        if (expect_push) begin
            if (which == 7) q7.push_back({d, fe, pe});
            else            q8.push_back({d, fe, pe});
        end
        for (int s = 0; s < nstop; s++) begin
            drive(which, stops[s]);
            if (pop_at_push && s == nstop - 1) begin
                wait_ticks(9);
                @(posedge clk);
                #2 ready = 1'b1;
                @(posedge clk);
                #2 ready = 1'b0;
                wait_ticks(6);
            end else begin
                wait_ticks(OS);
            end
        end
    endtask

    // Scoreboard monitors: compare every entry the consumer accepts
    always @(negedge clk) begin
        if (!reset && v8 && ready) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected8: got %h expected none", data8);
            end else begin
                check("entry8", {5'b0, 1'b0, data8, fe8, pe8}, {5'b0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && v7) begin
            if (q7.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected7: got %h expected none", data7);
            end else begin
                check("entry7", {5'b0, 2'b0, data7, fe7, pe7}, {5'b0, q7.pop_front()});
            end
        end
    end

    initial begin
        logic [8:0] d;
        logic       pb, sb;
        repeat (4) @(posedge clk);
        #2;
        check("reset_state8", {4'b0, v8, data8, fe8, pe8, ov8}, 16'h0);
        check("reset_state7", {5'b0, v7, data7, fe7, pe7, ov7}, 16'h0);
        reset = 1'b0;
        wait_ticks(4);

        pen = 1'b1; podd = 1'b0;
        send_frame(8, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(4);
        check("popped_empty", {7'b0, v8, data8}, 16'h0);

        send_frame(8, 9'h03C, 1'b1, 2'b11, 1'b1, 1'b0);
        idle(3);
        podd = 1'b1;
        send_frame(8, 9'h03C, 1'b1, 2'b11, 1'b1, 1'b0);
        idle(3);

        for (int n = 0; n < 16; n++) begin
            d    = 9'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pb   = 1'(($countones(d) + int'(podd)) % 2) ^ ($urandom_range(0, 3) == 0);
            sb   = ($urandom_range(0, 4) != 0);
            send_frame(8, d, pb, {1'b1, sb}, 1'b1, 1'b0);
            idle(3);
        end

        pen = 1'b0;
        send_frame(8, 9'h081, 1'b0, 2'b10, 1'b1, 1'b0);
        wait_ticks(3 * OS);
        check("break_single", 16'(q8.size()), 16'd0);
        idle(4);
        send_frame(8, 9'h055, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(4);

        drive(8, 1'b0);
        wait_ticks(4);
        drive(8, 1'b1);
        wait_ticks(2 * OS);
        check("glitch_no_entry", {7'b0, v8, data8}, 16'h0);

        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8, 9'(k), 1'b0, 2'b11, (k <= 4), 1'b0);
            idle(2);
        end
        check("overrun_set", {15'b0, ov8}, 16'h1);
        check("full_head", {7'b0, v8, data8}, 16'h101);
        send_frame(8, 9'h006, 1'b0, 2'b11, 1'b1, 1'b1);
        idle(2);
        ready = 1'b1;
        wait_ticks(4);
        check("drained", 16'(q8.size()), 16'd0);
        check("overrun_sticky", {15'b0, ov8}, 16'h1);
        en = 1'b0;
        @(posedge clk);
        #2;
        check("disable_clears", {4'b0, v8, data8, fe8, pe8, ov8}, 16'h0);
        en = 1'b1;
        idle(2);

        ready = 1'b0;
        send_frame(8, 9'h011, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(2);
        check("held_before_reset", {7'b0, v8, data8}, 16'h111);
        drive(8, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            drive(8, 1'(i % 2));
            wait_ticks(OS);
        end
        drive(8, 1'b0);
        wait_ticks(5);
        reset = 1'b1;
        rxd8  = 1'b1;
        #1;
        check("reset_midframe", {4'b0, v8, data8, fe8, pe8, ov8}, 16'h0);
        q8.delete();
        q7.delete();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        ready = 1'b1;
        idle(4);
        send_frame(8, 9'h05A, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(4);

        send_frame(7, 9'h02A, 1'b0, 2'b01, 1'b1, 1'b0);
        idle(4);
        send_frame(7, 9'h015, 1'b0, 2'b11, 1'b1, 1'b0);
        idle(4);

        check("final_q8", 16'(q8.size()), 16'd0);
        check("final_q7", 16'(q7.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised, oversampling UART receiver; successor to the fixed 8N1-with-parity receiver. It runs on one system clock with a one-cycle oversample tick. Data width, stop-bit count and oversample ratio are parameters; parity (none/even/odd) is selected at runtime. Received frames and their error flags go into a small first-word-fall-through FIFO with a valid/ready handshake and overrun detection. The block sits between the baud-tick generator and the host/bus interface.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit (even, >=8)
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, received-frame buffer entries (power of 2, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Rx_sample  input  1  oversample tick, one clk cycle wide, OVERSAMPLE x baud
Rx_EN  input  1  receiver enable; low = synchronous flush/idle
RxD  input  1  serial line, asynchronous, idle high
Rx_PARITY_EN  input  1  1 = parity bit present
Rx_PARITY_ODD  input  1  1 = odd parity, 0 = even parity
Rx_READY  input  1  consumer accepts head entry
Rx_DATA  output  DATA_BITS  FIFO head payload
Rx_FERROR  output  1  FIFO head framing-error flag
Rx_PERROR  output  1  FIFO head parity-error flag
Rx_VALID  output  1  FIFO non-empty
Rx_OVERRUN  output  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high) forces: all outputs 0, FIFO empty, state IDLE, synchroniser flops 1, counters 0.
- RxD passes through a 2-flop synchroniser on clk. All sampling uses the synchronised value and happens only on cycles with Rx_sample=1.
- Tick counter cnt is cleared on every state entry and increments on each tick.
- IDLE: on a tick with line=0, go to START.
- START: sample when cnt==OVERSAMPLE/2-1. If 0, go to DATA. If 1 (glitch), return to IDLE; no push.
- DATA: sample when cnt==OVERSAMPLE-1 into bit index i, starting at 0 (LSB). After bit DATA_BITS-1, go to PARITY if Rx_PARITY_EN, else STOP.
- PARITY: sample at OVERSAMPLE-1. expected = XOR(data) ^ Rx_PARITY_ODD. perr = (sample != expected).
- STOP: sample each stop bit at OVERSAMPLE-1. ferr is set if any stop sample is 0. After the last stop sample, push {data, ferr, perr} in that same cycle. Then go to IDLE if the last sample was 1, else go to BREAK_WAIT.
- BREAK_WAIT: stay until a tick with line=1, then go to IDLE. No start detection while in this state.
- Rx_PARITY_EN and Rx_PARITY_ODD are sampled at START->DATA and held for the rest of the frame.
- Data is pushed unmodified even when ferr or perr is set.
- FIFO is first-word-fall-through. Rx_DATA, Rx_FERROR and Rx_PERROR show the head entry whenever Rx_VALID=1, and are 0 when empty.
- Pop occurs on a clk edge with Rx_VALID & Rx_READY.
- Latency: Rx_VALID rises on the clk edge after the last stop-bit sample, when the FIFO was previously empty.
- Push while full with no pop: frame dropped, Rx_OVERRUN set to 1. Push while full with a simultaneous pop: both happen, no overrun. Push and pop on an empty FIFO: push only (Rx_VALID was 0).
- Rx_OVERRUN stays set until reset or Rx_EN=0.
- Rx_EN=0, synchronous, checked every clk: state IDLE, counters 0, FIFO flushed, all outputs 0. Rx_EN is not gated by the tick.
- Reset mid-frame aborts the frame. Reception restarts on the next falling edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each START, DATA, PARITY and STOP decision is the 2-of-3 majority of the samples at ticks mid-1, mid and mid+1 of the bit window. mid = OVERSAMPLE/2-1 in START and OVERSAMPLE-1 elsewhere, with window positions shifted accordingly.
- Undefined: single sample at the positions stated in Behaviour.
- Frame timing is identical in both builds.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT), FIFO entry struct {data, ferr, perr}, localparam widths via $clog2.
- Sub-module uart_rx_fifo: parametrised depth/width, FWFT, push/pop/full/empty, simultaneous push+pop when full allowed.

Test Plan:
- 0xA5, even parity bit 0, one stop bit -> Rx_VALID=1, Rx_DATA=0xA5, FERROR=0, PERROR=0; READY pop -> VALID=0.
- 0x3C sent with parity bit 1, even mode -> PERROR=1, Rx_DATA=0x3C. Same frame in odd mode -> PERROR=0.
- 0x81, stop bit 0, line held low 3 bit times -> one entry with FERROR=1 and no further frames; line high then 0x55 -> clean entry 0x55.
- Line low for 4 ticks, then high -> no entry, state back to IDLE, Rx_VALID stays 0.
- READY=0, frames 0x01..0x05 (DEPTH 4) -> OVERRUN=1, pops return 0x01..0x04 in order. Next frame arrives on the same cycle as a pop while full -> accepted. Rx_EN=0 -> OVERRUN=0.
- Reset pulse during bit 3 of a frame -> all outputs 0 immediately; next full frame 0x5A received correctly. Parameter sweep: DATA_BITS=7 with 2 stop bits, second stop bit 0 -> FERROR=1.
